// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-position common-cathode
//   seven-segment display. Steps through the digit slots and blanks each slot
//   briefly to suppress ghosting. Decodes BCD nibbles to segments and accepts
//   whole frames through a req/ack handshake. New frames are committed only
//   at frame boundaries, so a torn value is never shown.
//
// Optional build macro:
//   SEG_SCAN_LZB_EN - leading-zero blanking. Enabled digits above the
//                     highest nonzero nibble show no segments. Digit 0 is
//                     never blanked.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   upd_req    in   producer requests a frame commit (hold until upd_ack)
//   upd_data   in   4*NUM_DIGITS digit nibbles, digit 0 in bits [3:0]
//   upd_ack    out  one-cycle pulse, upd_data captured into the shadow frame
//   digit_en   in   per-digit enable, sampled every cycle
//   seg        out  segments a..g on bit6..bit0, active-high
//   cat        out  digit selects, active-low (bits >= NUM_DIGITS held 1)
//   frame_tick out  one-cycle pulse after each frame boundary

module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE   = 1000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    upd_req,
   input  logic [4*NUM_DIGITS-1:0] upd_data,
   output logic                    upd_ack,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [6:0]              seg,
   output logic [7:0]              cat,
   output logic                    frame_tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           pcnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] shadow;

   logic [3:0] nib [NUM_DIGITS];
   logic [7:0] sel_8;          // one-hot of the current slot, gated by digit_en
   logic       boundary;
   logic       load;
   logic [6:0] seg_next;
   logic [7:0] cat_next;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0:    decode = 7'b1111110;
         4'h1:    decode = 7'b0110000;
         4'h2:    decode = 7'b1101101;
         4'h3:    decode = 7'b1111001;
         4'h4:    decode = 7'b0110011;
         4'h5:    decode = 7'b1011011;
         4'h6:    decode = 7'b1011111;
         4'h7:    decode = 7'b1110000;
         4'h8:    decode = 7'b1111111;
         4'h9:    decode = 7'b1111011;
         4'hA:    decode = 7'b0000001;   // minus sign
         default: decode = 7'b0000000;   // blank
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi]   = shadow[4*gi+3:4*gi];
         assign sel_8[gi] = (idx == IW'(gi)) && digit_en[gi];
      end
      for (gi = NUM_DIGITS; gi < 8; gi++) begin : g_unused
         assign sel_8[gi] = 1'b0;
      end
   endgenerate

   assign boundary = (idx == IDX_LAST) && (pcnt == PCNT_LAST);
   assign load     = boundary && upd_req;

`ifdef SEG_SCAN_LZB_EN
   // Highest nonzero digit index. It is latched alongside the shadow frame,
   // so the blanking decision never needs a wide priority search per cycle.
   logic [IW-1:0] hi_nz;
   logic [IW-1:0] hi_calc;

   always_comb begin
      hi_calc = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (upd_data[4*i +: 4] != 4'd0) hi_calc = IW'(i);
      end
   end
`endif

   always_comb begin
      seg_next = 7'b0000000;
      cat_next = 8'hFF;
      if ((pcnt >= BLANK_END) && (|sel_8)) begin
         cat_next = ~sel_8;
         seg_next = decode(nib[idx]);
`ifdef SEG_SCAN_LZB_EN
         if (idx > hi_nz) seg_next = 7'b0000000;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt       <= '0;
         idx        <= '0;
         shadow     <= '0;
         seg        <= 7'b0000000;
         cat        <= 8'hFF;
         upd_ack    <= 1'b0;
         frame_tick <= 1'b0;
`ifdef SEG_SCAN_LZB_EN
         hi_nz      <= '0;
`endif
      end else begin
         if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
         frame_tick <= boundary;
         upd_ack    <= load;
         if (load) begin
            shadow <= upd_data;
`ifdef SEG_SCAN_LZB_EN
            hi_nz  <= hi_calc;
`endif
         end
         seg <= seg_next;
         cat <= cat_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=8, PRESCALE=8, BLANK_CYC=2).
// A reference model tracks the elapsed cycles since reset. From that count
// it derives the slot and phase arithmetically. It pushes the expected
// outputs for every clock edge into a queue. A monitor pops one entry on
// each falling edge and compares it with the DUT.

module tb_seg_scan_ctrl;

   localparam int ND = 8;
   localparam int P  = 8;
   localparam int BL = 2;
   localparam int FRAME = ND * P;

   typedef struct packed {
      logic       ack;
      logic       tick;
      logic [7:0] cat;
      logic [6:0] seg;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          upd_req = 1'b0;
   logic [31:0]   upd_data = 32'h0;
   logic          upd_ack;
   logic [ND-1:0] digit_en = '1;
   logic [6:0]    seg;
   logic [7:0]    cat;
   logic          frame_tick;

   int checks = 0;
   int errors = 0;

   obs_t exp_q[$];
   int   model_t = 0;

   logic [6:0] seg_tab [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b0000001, 7'b0000000,
      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

   seg_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(P), .BLANK_CYC(BL)) dut (
      .clk        (clk),
      .reset      (reset),
      .upd_req    (upd_req),
      .upd_data   (upd_data),
      .upd_ack    (upd_ack),
      .digit_en   (digit_en),
      .seg        (seg),
      .cat        (cat),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, req);
      end
   endtask

   // Reference model: behaviour from the display rules, using cycle arithmetic.
   initial begin : model
      logic [31:0] m_shadow;
      int          m_hi;
      int          slot, ph;
      bit          bnd;
      obs_t        e;
      m_shadow = 32'h0;
      m_hi     = 0;
      forever begin
         @(posedge clk);
         if (reset) begin
            model_t  = 0;
            m_shadow = 32'h0;
            m_hi     = 0;
            exp_q.delete();
         end else begin
            slot  = (model_t / P) % ND;
            ph    = model_t % P;
            bnd   = (model_t % FRAME) == FRAME - 1;
            e.cat = 8'hFF;
            e.seg = 7'b0;
            if (ph >= BL && digit_en[slot]) begin
               e.cat = ~(8'd1 << slot);
               e.seg = seg_tab[m_shadow[slot*4 +: 4]];
`ifdef SEG_SCAN_LZB_EN
               if (slot > m_hi) e.seg = 7'b0;
`endif
            end
            e.tick = bnd;
            e.ack  = bnd && upd_req;
            if (e.ack) begin
               m_shadow = upd_data;
               m_hi = 0;
               for (int i = 0; i < ND; i++)
                  if (upd_data[i*4 +: 4] != 4'h0) m_hi = i;
            end
            exp_q.push_back(e);
            model_t++;
         end
      end
   end

   // Monitor: compares every presented output against the scoreboard.
   initial begin : monitor
      obs_t e;
      obs_t a;
      forever begin
         @(negedge clk);
         a = '{ack: upd_ack, tick: frame_tick, cat: cat, seg: seg};
         if (reset) begin
            check("reset_state", 32'(a), 32'({1'b0, 1'b0, 8'hFF, 7'b0}));
         end else if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("scan_out{ack,tick,cat,seg}", 32'(a), 32'(e));
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic send_frame(input logic [31:0] d);
      bit got;
      got = 0;
      upd_data = d;
      upd_req  = 1'b1;
      for (int c = 0; c < 3 * FRAME; c++) begin
         step();
         if (upd_ack) begin
            got = 1;
            break;
         end
      end
      if (!got) check("ack_timeout", 32'd0, 32'd1);
      upd_req = 1'b0;
   endtask

   // Wait until the next clock edge processes cycle t with the given slot and phase.
   task automatic wait_pos(input int s, input int ph);
      bit hit;
      hit = 0;
      for (int c = 0; c < 4 * FRAME; c++) begin
         if (((model_t % FRAME) / P) == s && (model_t % P) == ph) begin
            hit = 1;
            break;
         end
         step();
      end
      if (!hit) check("slot_wait_timeout", 32'd0, 32'd1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      repeat (4) step();
      reset = 1'b0;

      // Idle frame with all-zero shadow, then the reference load.
      repeat (FRAME + 4) step();
      send_frame(32'h76543210);
      repeat (FRAME) step();

      // Request raised mid-frame at slot 3.
      wait_pos(3, 0);
      send_frame(32'h13572468);
      repeat (FRAME) step();

      // Upper digits disabled.
      digit_en = 8'h0F;
      repeat (FRAME + 8) step();
      digit_en = 8'hFF;

      // Minus sign and blank codes.
      send_frame(32'hFBA9FBA0);
      repeat (FRAME) step();

      // Randomized frames with digit_en changing every cycle.
      repeat (4) begin
         send_frame($urandom);
         repeat (FRAME + 5) begin
            step();
            digit_en = ND'($urandom);
         end
         digit_en = 8'hFF;
      end

      // Leading-zero pattern and all-zero frame.
      send_frame(32'h00000120);
      repeat (FRAME) step();
      send_frame(32'h00000000);
      repeat (FRAME) step();
      send_frame(32'hA9876543);
      repeat (FRAME) step();

      // Asynchronous reset during the slot 5 active phase.
      wait_pos(5, 5);
      step();
      reset = 1'b1;
      #1;
      check("async_reset_cat", 32'(cat), 32'h0000_00FF);
      check("async_reset_seg", 32'(seg), 32'h0);
      check("async_reset_ack", 32'(upd_ack), 32'h0);
      repeat (3) step();
      reset = 1'b0;
      repeat (2 * FRAME + 4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
